// File: rtl/rca_multicycle_stage_if.sv
// Handshake and adder-side bundle for rca_multicycle_stage.
// The master drives operands, the adder sum and downstream ready. The slave is the stage.
interface rca_multicycle_stage_if #(
  parameter int unsigned W = 23
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_x;
  logic [W-1:0] in_y;
  logic [W-1:0] add_x;
  logic [W-1:0] add_y;
  logic [W:0]   add_s;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   out_sum;
  logic         busy;

  modport master (
    output in_valid, in_x, in_y, add_s, out_ready,
    input  in_ready, add_x, add_y, out_valid, out_sum, busy
  );

  modport slave (
    input  in_valid, in_x, in_y, add_s, out_ready,
    output in_ready, add_x, add_y, out_valid, out_sum, busy
  );
endinterface

// File: rtl/rca_multicycle_stage.sv
// Feed/capture stage that holds the external ripple-carry adder inputs for SETTLE_CYC cycles, then samples its sum.
// Optional macro RCA_SUM_CHECK_EN adds a sticky chk_err output that compares the sampled sum against add_x+add_y.
module rca_multicycle_stage #(
  parameter int unsigned W          = 23,
  parameter int unsigned SETTLE_CYC = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  rca_multicycle_stage_if.slave   bus
`ifdef RCA_SUM_CHECK_EN
  ,
  output logic                    chk_err
`endif
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0] add_x_q;
  logic [W-1:0] add_y_q;
  logic [W:0]   out_sum_q;
  logic         out_valid_q;
  logic         accept;
  logic         capture;

  assign accept  = (state == IDLE) && bus.in_valid;
  assign capture = (state == SETTLE) && (cnt == '0);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nxt = SETTLE;
      SETTLE:  if (cnt == '0)     state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    bus.in_ready = 1'b0;
    bus.busy     = 1'b0;
    case (state)
      IDLE:    bus.in_ready = 1'b1;
      SETTLE:  bus.busy     = 1'b1;
      DONE:    bus.busy     = 1'b1;
      default: bus.in_ready = 1'b0;
    endcase
  end

  // Operand hold, settle countdown and sum capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      add_x_q     <= '0;
      add_y_q     <= '0;
      cnt         <= '0;
      out_sum_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        add_x_q <= bus.in_x;
        add_y_q <= bus.in_y;
        cnt     <= CNT_W'(SETTLE_CYC - 1);
      end else if ((state == SETTLE) && (cnt != '0)) begin
        cnt <= cnt - CNT_W'(1);
      end

      if (capture) begin
        out_sum_q   <= bus.add_s;
        out_valid_q <= 1'b1;
      end else if ((state == DONE) && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.add_x     = add_x_q;
  assign bus.add_y     = add_y_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_valid = out_valid_q;

`ifdef RCA_SUM_CHECK_EN
  logic [W:0] sum_ref;

  assign sum_ref = (W+1)'(add_x_q) + (W+1)'(add_y_q);

  // Sticky until reset so a single bad settle is never lost
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chk_err <= 1'b0;
    end else if (capture && (bus.add_s != sum_ref)) begin
      chk_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_rca_multicycle_stage.sv
// Scoreboard bench for rca_multicycle_stage with a behavioural external adder.
// Define RCA_SUM_CHECK_EN to also exercise chk_err.
module tb_rca_multicycle_stage;

  localparam int unsigned W          = 23;
  localparam int unsigned SETTLE_CYC = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flip  = 1'b0;

  always #5 clk = ~clk;

  rca_multicycle_stage_if #(.W(W)) bus ();

  // External adder model, with an optional bit-0 fault
  assign bus.add_s = ((W+1)'(bus.add_x) + (W+1)'(bus.add_y)) ^ {{W{1'b0}}, flip};

`ifdef RCA_SUM_CHECK_EN
  logic chk_err;
`endif

  rca_multicycle_stage #(.W(W), .SETTLE_CYC(SETTLE_CYC)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave)
`ifdef RCA_SUM_CHECK_EN
    ,
    .chk_err (chk_err)
`endif
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [W:0]   sb_q[$];
  int           acc_q[$];
  logic [W-1:0] last_x = '0;
  logic [W-1:0] last_y = '0;
  logic         prev_ov = 1'b0;
  logic         prev_hs = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: latency, pulse width, operand hold, scoreboard push/pop
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      acc_q.delete();
      prev_ov = 1'b0;
      prev_hs = 1'b0;
    end else begin
      if (prev_hs) check("ov_pulse", 32'(bus.out_valid), 32'd0);
      if (bus.out_valid && !prev_ov) begin
        if (acc_q.size() == 0) check("latency_unexpected", 32'd1, 32'd0);
        else check("latency", 32'(cyc - acc_q.pop_front()), 32'(SETTLE_CYC + 1));
      end
      if (bus.busy) begin
        check("hold_x", 32'(bus.add_x), 32'(last_x));
        check("hold_y", 32'(bus.add_y), 32'(last_y));
      end
      prev_hs = bus.out_valid && bus.out_ready;
      if (prev_hs) begin
        if (sb_q.size() == 0) check("sum_unexpected", 32'd1, 32'd0);
        else check("sum", 32'(bus.out_sum), 32'(sb_q.pop_front()));
      end
      prev_ov = bus.out_valid;
      if (bus.in_valid && bus.in_ready) begin
        sb_q.push_back(((W+1)'(bus.in_x) + (W+1)'(bus.in_y)) ^ {{W{1'b0}}, flip});
        acc_q.push_back(cyc);
        last_x = bus.in_x;
        last_y = bus.in_y;
      end
    end
  end

  // Call at posedge+1; returns at posedge+1 right after the accepting edge
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_x     = x;
    bus.in_y     = y;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
    end
    if (!ok) check("send_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !bus.busy) ok = 1'b1;
    end
    if (!ok) check("idle_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    logic [W:0] sum_hold;
    bit         seen;

    // Reset held with a pending in_valid
    bus.in_valid  = 1'b1;
    bus.in_x      = 23'h000055;
    bus.in_y      = 23'h0000AA;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_add_x",     32'(bus.add_x),     32'd0);
    check("rst_add_y",     32'(bus.add_y),     32'd0);
    check("rst_out_sum",   32'(bus.out_sum),   32'd0);
    @(posedge clk);
    #1;

    // Basic add and carry boundaries
    send(23'h000005, 23'h00000A);
    wait_idle(30);
    send(23'h7FFFFF, 23'h7FFFFF);
    wait_idle(30);
    send(23'h7FFFFF, 23'h000001);
    wait_idle(30);
    send(23'h000000, 23'h000000);
    wait_idle(30);
    for (int i = 0; i < 6; i++) begin
      send(W'($urandom), W'($urandom));
      wait_idle(30);
    end

    // Backpressure: result must hold and a new pair must be ignored
    bus.out_ready = 1'b0;
    send(23'h123456, 23'h000111);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    if (!seen) check("bp_timeout", 32'd1, 32'd0);
    sum_hold = bus.out_sum;
    check("bp_sum", 32'(sum_hold), 32'h123567);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.in_x     = 23'h000007;
    bus.in_y     = 23'h000007;
    repeat (10) begin
      @(negedge clk);
      check("bp_hold_sum",   32'(bus.out_sum),   32'(sum_hold));
      check("bp_in_ready",   32'(bus.in_ready),  32'd0);
      check("bp_out_valid",  32'(bus.out_valid), 32'd1);
    end
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    wait_idle(30);

    // Reset in the second settle cycle abandons the transaction
    send(23'h000100, 23'h000200);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    check("midrst_busy",     32'(bus.busy),     32'd0);
    repeat (6) begin
      @(negedge clk);
      check("midrst_no_ov", 32'(bus.out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    send(23'h000001, 23'h000001);
    wait_idle(30);

`ifdef RCA_SUM_CHECK_EN
    check("chk_err_clean", 32'(chk_err), 32'd0);
    flip = 1'b1;
    send(23'h000003, 23'h000004);
    wait_idle(30);
    flip = 1'b0;
    check("chk_err_set", 32'(chk_err), 32'd1);
    send(23'h00000A, 23'h000014);
    wait_idle(30);
    check("chk_err_sticky", 32'(chk_err), 32'd1);
`endif

    if (sb_q.size() != 0) check("sb_leftover", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
